// File: rtl/pa_clic_arb_seq.sv
// pa_clic_arb_seq: sweeping CLIC pending-interrupt arbiter, compares GRP_SIZE sources per cycle against a running best.
// Latency: one IDLE->SCAN edge, then NGRP edges per sweep (only non-empty groups with CLIC_ARB_SEQ_SKIP_EN defined).
// Backpressure: none; the published winner is held until the next sweep end, and ctrl ack/flush clears it.
module pa_clic_arb_seq #(
  parameter int INT_NUM  = 64,
  parameter int CTLBITS  = 3,
  parameter int GRP_SIZE = 16,
  parameter int ID_WIDTH = 12
) (
  input  logic                             forever_cpuclk,
  input  logic                             cpurst,
  input  logic [INT_NUM-1:0]               kid_arb_int_req,
  input  logic [INT_NUM-1:0]               kid_arb_int_hv,
  input  logic [(CTLBITS+1)*INT_NUM-1:0]   kid_arb_int_all_vec,
  input  logic [CTLBITS-1:0]               ctrl_xx_int_lv_or_mask,
  input  logic                             ctrl_arb_int_ack,
  input  logic                             ctrl_arb_flush,
  output logic                             arb_ctrl_int_vld,
  output logic [ID_WIDTH-1:0]              arb_ctrl_int_id,
  output logic                             arb_ctrl_int_hv,
  output logic                             arb_ctrl_int_mode,
  output logic [7:0]                       arb_ctrl_int_il,
  output logic                             arb_ctrl_int_req_raw
);

  localparam int PRIO_WIDTH = CTLBITS + 1;
  localparam int NGRP       = INT_NUM / GRP_SIZE;
  localparam int GRP_W      = $clog2(NGRP);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  state, state_nxt;
  logic [GRP_W-1:0]        grp_ptr, grp_ptr_nxt;
  logic                    best_vld, best_vld_nxt;
  logic [PRIO_WIDTH-1:0]   best_prio, best_prio_nxt;
  logic [ID_WIDTH-1:0]     best_id, best_id_nxt;
  logic                    best_hv, best_hv_nxt;

  logic                    out_vld_nxt;
  logic [ID_WIDTH-1:0]     out_id_nxt;
  logic                    out_hv_nxt;
  logic                    out_mode_nxt;
  logic [7:0]              out_il_nxt;

  // Per-group views of the flat source vectors, indexed by grp_ptr.
  logic [GRP_SIZE-1:0]                  grp_req [NGRP];
  logic [GRP_SIZE-1:0]                  grp_hvs [NGRP];
  logic [GRP_SIZE-1:0][PRIO_WIDTH-1:0]  grp_prv [NGRP];

  for (genvar g = 0; g < NGRP; g++) begin : g_split
    assign grp_req[g] = kid_arb_int_req[g*GRP_SIZE +: GRP_SIZE];
    assign grp_hvs[g] = kid_arb_int_hv[g*GRP_SIZE +: GRP_SIZE];
    assign grp_prv[g] = kid_arb_int_all_vec[g*GRP_SIZE*PRIO_WIDTH +: GRP_SIZE*PRIO_WIDTH];
  end

  logic [GRP_SIZE-1:0]                  cur_req;
  logic [GRP_SIZE-1:0]                  cur_hv;
  logic [GRP_SIZE-1:0][PRIO_WIDTH-1:0]  cur_prio;

  assign cur_req  = grp_req[grp_ptr];
  assign cur_hv   = grp_hvs[grp_ptr];
  assign cur_prio = grp_prv[grp_ptr];

  assign arb_ctrl_int_req_raw = |kid_arb_int_req;

  // Sweep sequencing: where a sweep starts, where it steps next, and whether this cycle ends it.
  logic [GRP_W-1:0] start_grp;
  logic [GRP_W-1:0] step_grp;
  logic             sweep_end;

`ifdef CLIC_ARB_SEQ_SKIP_EN
  logic [NGRP-1:0]  grp_any;
  logic [GRP_W-1:0] first_grp;
  logic [GRP_W-1:0] nxt_grp;
  logic             nxt_found;

  for (genvar g = 0; g < NGRP; g++) begin : g_any
    assign grp_any[g] = |grp_req[g];
  end

  // Lowest non-empty group overall and lowest non-empty group above the current pointer.
  always_comb begin
    first_grp = '0;
    nxt_grp   = '0;
    nxt_found = 1'b0;
    for (int g = NGRP - 1; g >= 0; g--) begin
      if (grp_any[g]) begin
        first_grp = GRP_W'(g);
      end
      if (grp_any[g] && (GRP_W'(g) > grp_ptr)) begin
        nxt_grp   = GRP_W'(g);
        nxt_found = 1'b1;
      end
    end
  end

  assign start_grp = first_grp;
  assign step_grp  = nxt_grp;
  assign sweep_end = !nxt_found;
`else
  assign start_grp = '0;
  assign step_grp  = grp_ptr + 1'b1;
  assign sweep_end = (grp_ptr == GRP_W'(NGRP - 1));
`endif

  logic                  grp_vld;
  logic [PRIO_WIDTH-1:0] grp_prio;
  logic [ID_WIDTH-1:0]   grp_loc;
  logic                  grp_hv;
  logic                  mrg_vld;
  logic [PRIO_WIDTH-1:0] mrg_prio;
  logic [ID_WIDTH-1:0]   mrg_id;
  logic                  mrg_hv;
  logic [7:0]            mrg_il;

  // Pick the group winner (strict > keeps the lowest index on ties), then merge with the running best.
  always_comb begin
    grp_vld  = 1'b0;
    grp_prio = '0;
    grp_loc  = '0;
    grp_hv   = 1'b0;
    for (int j = 0; j < GRP_SIZE; j++) begin
      if (cur_req[j] && (!grp_vld || (cur_prio[j] > grp_prio))) begin
        grp_vld  = 1'b1;
        grp_prio = cur_prio[j];
        grp_loc  = ID_WIDTH'(j);
        grp_hv   = cur_hv[j];
      end
    end
    // The running best always holds lower ids, so it keeps ties.
    if (grp_vld && (!best_vld || (grp_prio > best_prio))) begin
      mrg_vld  = 1'b1;
      mrg_prio = grp_prio;
      mrg_id   = ID_WIDTH'(grp_ptr) * ID_WIDTH'(GRP_SIZE) + grp_loc;
      mrg_hv   = grp_hv;
    end else begin
      mrg_vld  = best_vld;
      mrg_prio = best_prio;
      mrg_id   = best_id;
      mrg_hv   = best_hv;
    end
    mrg_il = mrg_vld ? ((8'(mrg_prio[CTLBITS-1:0] | ctrl_xx_int_lv_or_mask) << (8 - CTLBITS))
                        | (8'hFF >> CTLBITS))
                     : 8'h00;
  end

  // Next state: req drop beats ack/flush, which beats publishing at sweep end.
  always_comb begin
    state_nxt     = state;
    grp_ptr_nxt   = grp_ptr;
    best_vld_nxt  = best_vld;
    best_prio_nxt = best_prio;
    best_id_nxt   = best_id;
    best_hv_nxt   = best_hv;
    out_vld_nxt   = arb_ctrl_int_vld;
    out_id_nxt    = arb_ctrl_int_id;
    out_hv_nxt    = arb_ctrl_int_hv;
    out_mode_nxt  = arb_ctrl_int_mode;
    out_il_nxt    = arb_ctrl_int_il;
    case (state)
      IDLE: begin
        if (arb_ctrl_int_req_raw) begin
          state_nxt     = SCAN;
          grp_ptr_nxt   = start_grp;
          best_vld_nxt  = 1'b0;
          best_prio_nxt = '0;
          best_id_nxt   = '0;
          best_hv_nxt   = 1'b0;
        end
      end
      SCAN: begin
        if (!arb_ctrl_int_req_raw || ctrl_arb_int_ack || ctrl_arb_flush || sweep_end) begin
          state_nxt     = arb_ctrl_int_req_raw ? SCAN : IDLE;
          grp_ptr_nxt   = arb_ctrl_int_req_raw ? start_grp : '0;
          best_vld_nxt  = 1'b0;
          best_prio_nxt = '0;
          best_id_nxt   = '0;
          best_hv_nxt   = 1'b0;
          if (!arb_ctrl_int_req_raw || ctrl_arb_int_ack || ctrl_arb_flush) begin
            out_vld_nxt  = 1'b0;
            out_id_nxt   = '0;
            out_hv_nxt   = 1'b0;
            out_mode_nxt = 1'b0;
            out_il_nxt   = 8'h00;
          end else begin
            out_vld_nxt  = mrg_vld;
            out_id_nxt   = mrg_vld ? mrg_id : '0;
            out_hv_nxt   = mrg_vld & mrg_hv;
            out_mode_nxt = mrg_vld & mrg_prio[CTLBITS];
            out_il_nxt   = mrg_il;
          end
        end else begin
          grp_ptr_nxt   = step_grp;
          best_vld_nxt  = mrg_vld;
          best_prio_nxt = mrg_prio;
          best_id_nxt   = mrg_id;
          best_hv_nxt   = mrg_hv;
        end
      end
      default: begin
        state_nxt   = IDLE;
        grp_ptr_nxt = '0;
      end
    endcase
  end

  // State, running best and published outputs.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state             <= IDLE;
      grp_ptr           <= '0;
      best_vld          <= 1'b0;
      best_prio         <= '0;
      best_id           <= '0;
      best_hv           <= 1'b0;
      arb_ctrl_int_vld  <= 1'b0;
      arb_ctrl_int_id   <= '0;
      arb_ctrl_int_hv   <= 1'b0;
      arb_ctrl_int_mode <= 1'b0;
      arb_ctrl_int_il   <= 8'h00;
    end else begin
      state             <= state_nxt;
      grp_ptr           <= grp_ptr_nxt;
      best_vld          <= best_vld_nxt;
      best_prio         <= best_prio_nxt;
      best_id           <= best_id_nxt;
      best_hv           <= best_hv_nxt;
      arb_ctrl_int_vld  <= out_vld_nxt;
      arb_ctrl_int_id   <= out_id_nxt;
      arb_ctrl_int_hv   <= out_hv_nxt;
      arb_ctrl_int_mode <= out_mode_nxt;
      arb_ctrl_int_il   <= out_il_nxt;
    end
  end

endmodule
